// File: rtl/sumador_arbitro_pkg.sv
// Shared definitions for the two-client adder arbiter: FSM encoding and client IDs.
// No logic here; imported by every file in this block.
package sumador_arbitro_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  localparam logic CLIENT0 = 1'b0;
  localparam logic CLIENT1 = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = IDLE,
    S_CALC = CALC,
    S_HOLD = HOLD
  } state_e;

endpackage

// File: rtl/sumador_arbitro_rca.sv
// Parameterized N-bit ripple-carry adder, carry-in tied to 0, N+1-bit result.
// Purely combinational, zero latency; no flow control.
module sumador_arbitro_rca #(
  parameter int N = 5
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N:0]   sum_o
);

  logic [N:0] carry;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < N; i++) begin : g_bit
    assign sum_o[i]    = a_i[i] ^ b_i[i] ^ carry[i];
    assign carry[i+1]  = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
  end

  assign sum_o[N] = carry[N];

endmodule

// File: rtl/sumador_arbitro_rr_arbiter2.sv
// Two-way round-robin arbiter: one-hot grant, ties go to the client that was not granted last.
// Purely combinational, zero latency; a grant is only ever issued to a requesting client.
module rr_arbiter2
  import sumador_arbitro_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o    = 2'b00;
    gnt_o[0] = req_i[0] & (~req_i[1] | (last_grant_i == CLIENT1));
    gnt_o[1] = req_i[1] & (~req_i[0] | (last_grant_i == CLIENT0));
  end

endmodule

// File: rtl/sumador_arbitro.sv
// Arbitrates two clients onto one shared adder; result valid one edge after the CALC cycle.
// Requests accepted only in IDLE; HOLD stalls with stable outputs until res_ready.
module sumador_arbitro
  import sumador_arbitro_pkg::*;
#(
  parameter int N = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  output logic         req1_ready,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [N:0]   res_sum,
  output logic         res_id,
  output logic         busy
);

  state_e       state_q, state_d;
  logic [N-1:0] a_q, a_d, b_q, b_d;
  logic         id_q, id_d;
  logic         last_grant_q, last_grant_d;
  logic         res_valid_q, res_valid_d;
  logic [N:0]   res_sum_q, res_sum_d;
  logic         res_id_q, res_id_d;

  logic [1:0]   gnt;
  logic [N:0]   adder_sum;
  logic         req_hs;

  rr_arbiter2 u_arb (
    .req_i        ({req1_valid, req0_valid}),
    .last_grant_i (last_grant_q),
    .gnt_o        (gnt)
  );

  sumador_arbitro_rca #(.N(N)) u_rca (
    .a_i   (a_q),
    .b_i   (b_q),
    .sum_o (adder_sum)
  );

  assign req0_ready = (state_q == S_IDLE) && gnt[0];
  assign req1_ready = (state_q == S_IDLE) && gnt[1];
  assign req_hs     = req0_ready | req1_ready;

  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    id_d         = id_q;
    last_grant_d = last_grant_q;
    res_valid_d  = res_valid_q;
    res_sum_d    = res_sum_q;
    res_id_d     = res_id_q;
    case (state_q)
      S_IDLE: begin
        if (req_hs) begin
          state_d      = S_CALC;
          a_d          = gnt[1] ? req1_a : req0_a;
          b_d          = gnt[1] ? req1_b : req0_b;
          id_d         = gnt[1] ? CLIENT1 : CLIENT0;
          last_grant_d = gnt[1] ? CLIENT1 : CLIENT0;
        end
      end
      S_CALC: begin
        state_d     = S_HOLD;
        res_sum_d   = adder_sum;
        res_id_d    = id_q;
        res_valid_d = 1'b1;
      end
      S_HOLD: begin
        // res_sum/res_id deliberately keep their value after the result handshake.
        if (res_ready) begin
          state_d     = S_IDLE;
          res_valid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      a_q          <= '0;
      b_q          <= '0;
      id_q         <= CLIENT0;
      last_grant_q <= CLIENT1;
      res_valid_q  <= 1'b0;
      res_sum_q    <= '0;
      res_id_q     <= CLIENT0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      id_q         <= id_d;
      last_grant_q <= last_grant_d;
      res_valid_q  <= res_valid_d;
      res_sum_q    <= res_sum_d;
      res_id_q     <= res_id_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_sum   = res_sum_q;
  assign res_id    = res_id_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_sumador_arbitro.sv
// Directed bench for sumador_arbitro (N=5) with hand-computed expected sums and grant order.
module tb_sumador_arbitro;

  localparam int N = 5;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req1_valid;
  logic [N-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         req0_ready, req1_ready;
  logic         res_valid, res_ready;
  logic [N:0]   res_sum;
  logic         res_id;
  logic         busy;

  int errors = 0;
  int checks = 0;
  int res_xfers = 0;
  int xfer_snap;

  sumador_arbitro #(.N(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ready (req1_ready),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_sum    (res_sum),
    .res_id     (res_id),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (rst_n && res_valid && res_ready) res_xfers <= res_xfers + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One client-only transaction with res_ready high: check handshake, result, return to IDLE.
  task automatic single(input int cl, input int a, input int b, input int exp_sum);
    if (cl == 0) begin
      req0_valid = 1'b1; req0_a = N'(a); req0_b = N'(b);
    end else begin
      req1_valid = 1'b1; req1_a = N'(a); req1_b = N'(b);
    end
    res_ready = 1'b1;
    #1;
    chk("single_rdy", {31'd0, (cl == 0) ? req0_ready : req1_ready}, 1);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    chk("single_calc_busy", {31'd0, busy}, 1);
    tick();
    chk("single_vld", {31'd0, res_valid}, 1);
    chk("single_sum", {26'd0, res_sum}, exp_sum);
    chk("single_id", {31'd0, res_id}, cl);
    tick();
    chk("single_done", {30'd0, busy, res_valid}, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    res_ready = 1'b0;
    #12;
    chk("rst_vld", {31'd0, res_valid}, 0);
    chk("rst_sum", {26'd0, res_sum}, 0);
    chk("rst_id_busy", {30'd0, res_id, busy}, 0);
    rst_n = 1'b1;
    tick();

    // 3+4 on client 0, cycle by cycle
    req0_valid = 1'b1; req0_a = 5'd3; req0_b = 5'd4; res_ready = 1'b1;
    #1;
    chk("t1_rdy0", {31'd0, req0_ready}, 1);
    chk("t1_rdy1", {31'd0, req1_ready}, 0);
    chk("t1_busy_idle", {31'd0, busy}, 0);
    tick();
    req0_valid = 1'b0;
    #1;
    chk("t1_calc", {29'd0, busy, res_valid, req0_ready}, 3'b100);
    tick();
    chk("t1_hold", {30'd0, busy, res_valid}, 2'b11);
    chk("t1_sum", {26'd0, res_sum}, 7);
    chk("t1_id", {31'd0, res_id}, 0);
    tick();
    chk("t1_idle", {30'd0, busy, res_valid}, 0);
    chk("t1_sum_kept", {26'd0, res_sum}, 7);

    // Carry into the MSB
    single(1, 31, 1, 32);

    // Reset during CALC: outputs clear without a clock edge, no stale result
    req0_valid = 1'b1; req0_a = 5'd2; req0_b = 5'd2; res_ready = 1'b1;
    tick();
    req0_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_vld", {31'd0, res_valid}, 0);
    chk("rst_mid_busy", {31'd0, busy}, 0);
    chk("rst_mid_sum", {26'd0, res_sum}, 0);
    chk("rst_mid_id", {31'd0, res_id}, 0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_no_stale", {30'd0, res_valid, busy}, 0);
    end

    // Both valid after reset: strict alternation starting with client 0
    req0_valid = 1'b1; req0_a = 5'd31; req0_b = 5'd31;
    req1_valid = 1'b1; req1_a = 5'd1;  req1_b = 5'd0;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("alt_rdy", {30'd0, req1_ready, req0_ready}, (k % 2 == 0) ? 2'b01 : 2'b10);
      tick();
      tick();
      chk("alt_hold_rdy", {30'd0, req1_ready, req0_ready}, 0);
      chk("alt_sum", {26'd0, res_sum}, (k % 2 == 0) ? 62 : 1);
      chk("alt_id", {31'd0, res_id}, k % 2);
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();

    // Stall in HOLD with client 1 waiting
    req0_valid = 1'b1; req0_a = 5'd10; req0_b = 5'd5; res_ready = 1'b0;
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_a = 5'd6; req1_b = 5'd7;
    tick();
    xfer_snap = res_xfers;
    for (int i = 0; i < 5; i++) begin
      chk("stall_vld", {31'd0, res_valid}, 1);
      chk("stall_sum", {26'd0, res_sum}, 15);
      chk("stall_id", {31'd0, res_id}, 0);
      chk("stall_rdy", {30'd0, req1_ready, req0_ready}, 0);
      tick();
    end
    res_ready = 1'b1;
    tick();
    chk("stall_release_vld", {31'd0, res_valid}, 0);
    chk("stall_one_xfer", res_xfers - xfer_snap, 1);
    chk("stall_next_rdy1", {31'd0, req1_ready}, 1);
    tick();
    req1_valid = 1'b0;
    tick();
    chk("stall_next_sum", {26'd0, res_sum}, 13);
    chk("stall_next_id", {31'd0, res_id}, 1);
    chk("stall_total_xfer", res_xfers - xfer_snap, 1);
    tick();
    chk("stall_total_xfer2", res_xfers - xfer_snap, 2);

    // Client 0 served, so client 1 wins the next tie; client 0 then drops out
    single(0, 5, 5, 10);
    req0_valid = 1'b1; req0_a = 5'd1; req0_b = 5'd1;
    req1_valid = 1'b1; req1_a = 5'd9; req1_b = 5'd8;
    #1;
    chk("drop_rdy", {30'd0, req1_ready, req0_ready}, 2'b10);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    chk("drop_sum", {26'd0, res_sum}, 17);
    chk("drop_id", {31'd0, res_id}, 1);
    tick();
    #1;
    chk("drop_idle_rdy", {29'd0, busy, req1_ready, req0_ready}, 0);
    tick();
    chk("drop_no_serve", {31'd0, busy}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
